// File: rtl/gray_pkg.sv
// Shared types, coefficients and packing helper for the gray video pipe.
// Optional binarisation is selected with the GRAY_THRESH_EN macro.
package gray_pkg;

    typedef enum logic [1:0] {
        WEIGHTED = 2'd0,
        AVERAGE  = 2'd1,
        GREEN    = 2'd2,
        BYPASS   = 2'd3
    } gray_mode_e;

    localparam logic [7:0] C_R   = 8'd77;
    localparam logic [7:0] C_G   = 8'd150;
    localparam logic [7:0] C_B   = 8'd29;
    localparam logic [7:0] C_AVG = 8'd85;

    localparam int PIPE_LAT = 3;

    function automatic logic [15:0] pack565(input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters, raw (active-high) syncs, active flag and pixel coordinates.
// Region order from count zero: sync, back porch, active, front porch.
module video_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          active_o,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_start_o,
    output logic          origin_o
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SY   = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ST   = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_EN   = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SY   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ST   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_EN   = VW'(V_SYNC + V_BACK + V_ACTIVE);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_act, v_act;

    // Next raster position: hcnt wraps each line, vcnt steps on that wrap.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Region decode and coordinates; coordinates read zero outside active.
    always_comb begin
        h_act         = (hcnt_q >= H_ST) && (hcnt_q < H_EN);
        v_act         = (vcnt_q >= V_ST) && (vcnt_q < V_EN);
        active_o      = h_act && v_act;
        pix_x_o       = active_o ? XW'(hcnt_q - H_ST) : '0;
        pix_y_o       = active_o ? YW'(vcnt_q - V_ST) : '0;
        hsync_o       = hcnt_q < H_SY;
        vsync_o       = vcnt_q < V_SY;
        frame_start_o = active_o && (hcnt_q == H_ST) && (vcnt_q == V_ST);
        origin_o      = (hcnt_q == '0) && (vcnt_q == '0);
    end

endmodule

// File: rtl/gray_video_pipe.sv
// Video timing plus 3-stage RGB888 -> gray -> RGB565 conversion pipeline.
// Define GRAY_THRESH_EN to add the bin_en/thresh binarisation inputs.
module gray_video_pipe
    import gray_pkg::*;
#(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
`ifdef GRAY_THRESH_EN
    input  logic                        bin_en,
    input  logic [7:0]                  thresh,
`endif
    output logic                        pix_req,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    input  logic [23:0]                 rgb_in,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic                        frame_start,
    output logic [15:0]                 rgb
);

    logic hs_raw, vs_raw, fs_raw, origin;

    video_timing_gen #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACTIVE(H_ACTIVE),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .active_o     (pix_req),
        .pix_x_o      (pix_x),
        .pix_y_o      (pix_y),
        .hsync_o      (hs_raw),
        .vsync_o      (vs_raw),
        .frame_start_o(fs_raw),
        .origin_o     (origin)
    );

    gray_mode_e mode_q;
`ifdef GRAY_THRESH_EN
    logic       bin_q;
    logic [7:0] thr_q;
`endif

    // Frame-level settings only move at raster origin, never mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= WEIGHTED;
`ifdef GRAY_THRESH_EN
            bin_q  <= 1'b0;
            thr_q  <= '0;
`endif
        end else if (origin) begin
            mode_q <= gray_mode_e'(mode);
`ifdef GRAY_THRESH_EN
            bin_q  <= bin_en;
            thr_q  <= thresh;
`endif
        end
    end

    logic [PIPE_LAT-1:0] de_q, hs_q, vs_q, fs_q;

    // Control delay line; syncs stored already at their output polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q <= '0;
            hs_q <= {PIPE_LAT{~SYNC_POL}};
            vs_q <= {PIPE_LAT{~SYNC_POL}};
            fs_q <= '0;
        end else begin
            de_q <= {de_q[PIPE_LAT-2:0], pix_req};
            hs_q <= {hs_q[PIPE_LAT-2:0], hs_raw ~^ SYNC_POL};
            vs_q <= {vs_q[PIPE_LAT-2:0], vs_raw ~^ SYNC_POL};
            fs_q <= {fs_q[PIPE_LAT-2:0], fs_raw};
        end
    end

    logic [7:0]  cr_d, cg_d, cb_d;
    logic [15:0] p0_d, p1_d, p2_d;

    // Stage 1 products; the average mode reuses the same three multipliers.
    always_comb begin
        cr_d = C_R;
        cg_d = C_G;
        cb_d = C_B;
        if (mode_q == AVERAGE) begin
            cr_d = C_AVG;
            cg_d = C_AVG;
            cb_d = C_AVG;
        end
        p0_d = 16'(cr_d) * 16'(rgb_in[23:16]);
        p1_d = 16'(cg_d) * 16'(rgb_in[15:8]);
        p2_d = 16'(cb_d) * 16'(rgb_in[7:0]);
    end

    logic [15:0] s1_p0_q, s1_p1_q, s1_p2_q;
    logic [7:0]  s1_r_q, s1_g_q, s1_b_q;
    gray_mode_e  s1_mode_q;
`ifdef GRAY_THRESH_EN
    logic        s1_bin_q;
    logic [7:0]  s1_thr_q;
`endif

    // Stage 1 register; data without a live request is dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p0_q   <= '0;
            s1_p1_q   <= '0;
            s1_p2_q   <= '0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_mode_q <= WEIGHTED;
`ifdef GRAY_THRESH_EN
            s1_bin_q  <= 1'b0;
            s1_thr_q  <= '0;
`endif
        end else begin
            s1_p0_q   <= de_q[0] ? p0_d : '0;
            s1_p1_q   <= de_q[0] ? p1_d : '0;
            s1_p2_q   <= de_q[0] ? p2_d : '0;
            s1_r_q    <= de_q[0] ? rgb_in[23:16] : '0;
            s1_g_q    <= de_q[0] ? rgb_in[15:8] : '0;
            s1_b_q    <= de_q[0] ? rgb_in[7:0] : '0;
            s1_mode_q <= mode_q;
`ifdef GRAY_THRESH_EN
            s1_bin_q  <= bin_q;
            s1_thr_q  <= thr_q;
`endif
        end
    end

    logic [17:0] sum_d;
    logic [7:0]  g_d;
    logic [15:0] pix_d;

    // Stage 2 sum and scale, then select the packed output word.
    always_comb begin
        sum_d = 18'(s1_p0_q) + 18'(s1_p1_q) + 18'(s1_p2_q);
        g_d   = (s1_mode_q == GREEN) ? s1_g_q : 8'(sum_d >> 8);
        pix_d = pack565(g_d, g_d, g_d);
        if (s1_mode_q == BYPASS) begin
            pix_d = pack565(s1_r_q, s1_g_q, s1_b_q);
        end
`ifdef GRAY_THRESH_EN
        else if (s1_bin_q) begin
            pix_d = (g_d >= s1_thr_q) ? 16'hFFFF : 16'h0000;
        end
`endif
    end

    logic [15:0] rgb_q;

    // Output register, blanked whenever the aligned data enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= de_q[PIPE_LAT-2] ? pix_d : '0;
        end
    end

    assign rgb         = rgb_q;
    assign de          = de_q[PIPE_LAT-1];
    assign hsync       = hs_q[PIPE_LAT-1];
    assign vsync       = vs_q[PIPE_LAT-1];
    assign frame_start = fs_q[PIPE_LAT-1];

endmodule
